lfsr_checker: RTL and testbench

- Receive-side companion to the 4-bit LFSR random-number generator used in the High/Low game datapath.
- Accepts the stream of 4-bit pseudo-random values produced elsewhere, self-synchronises to it, then predicts each next value and flags/counts mismatches.
- Used to monitor the game's random source on the board and as a self-checking monitor in benches.

---
 rtl/lfsr_checker_pkg.sv | 14 +
 rtl/lfsr_next.sv | 11 +
 rtl/lfsr_checker.sv | 126 ++++++++++++
 tb/tb_lfsr_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 4-bit LFSR stream checker: state encoding, LFSR width and feedback taps.
package lfsr_checker_pkg;

   localparam int LFSR_W = 4;
   localparam int TAP_HI = 3;
   localparam int TAP_LO = 2;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/lfsr_next.sv
// Combinational 4-bit LFSR next-state function (shift left, feedback = q[3]^q[2]); zero latency, no flow control.
module lfsr_next
   import lfsr_checker_pkg::*;
(
   input  logic [LFSR_W-1:0] q,
   output logic [LFSR_W-1:0] next
);

   assign next = {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a 4-bit LFSR stream: predicts each sample, flags and counts mismatches once locked.
// One-cycle registered latency per sample; dataValid gates every update, full rate with no backpressure.
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dataValid,
   input  logic [LFSR_W-1:0] dataIn,
   output logic              locked,
   output logic              errorPulse,
   output logic [ERR_W-1:0]  errorCount,
   output logic [LFSR_W-1:0] expected
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);

   state_t            state, state_n;
   logic [3:0]        match_cnt, match_n;
   logic [3:0]        miss_cnt, miss_n;
   logic [LFSR_W-1:0] expected_n;
   logic              locked_n;
   logic              pulse_n;
   logic [ERR_W-1:0]  err_n;
   logic [LFSR_W-1:0] next_din;
   logic [LFSR_W-1:0] next_exp;

   lfsr_next u_next_din (
      .q    (dataIn),
      .next (next_din)
   );

   lfsr_next u_next_exp (
      .q    (expected),
      .next (next_exp)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         match_cnt  <= '0;
         miss_cnt   <= '0;
         expected   <= '0;
         locked     <= 1'b0;
         errorPulse <= 1'b0;
         errorCount <= '0;
      end else begin
         state      <= state_n;
         match_cnt  <= match_n;
         miss_cnt   <= miss_n;
         expected   <= expected_n;
         locked     <= locked_n;
         errorPulse <= pulse_n;
         errorCount <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      match_n    = match_cnt;
      miss_n     = miss_cnt;
      expected_n = expected;
      locked_n   = locked;
      pulse_n    = 1'b0;
      err_n      = errorCount;

      if (dataValid) begin
         case (state)
            HUNT: begin
               if (dataIn != '0) begin
                  expected_n = next_din;
                  match_n    = '0;
                  state_n    = VERIFY;
               end
            end
            VERIFY: begin
               if (dataIn == '0) begin
                  match_n = '0;
                  state_n = HUNT;
               end else if (dataIn == expected) begin
                  match_n    = match_cnt + 4'd1;
                  expected_n = next_din;
                  if (match_n == LOCK_LIM) begin
                     state_n  = LOCKED;
                     locked_n = 1'b1;
                  end
               end else begin
                  // Reseed from the offending sample rather than dropping to HUNT.
                  expected_n = next_din;
                  match_n    = '0;
               end
            end
            LOCKED: begin
               // Flywheel: prediction advances on its own so a bad sample cannot derail it.
               expected_n = next_exp;
               if (dataIn == expected) begin
                  miss_n = '0;
               end else begin
                  pulse_n = 1'b1;
                  miss_n  = miss_cnt + 4'd1;
                  if (errorCount != {ERR_W{1'b1}})
                     err_n = errorCount + ERR_W'(1);
                  if (miss_n == LOSS_LIM) begin
                     state_n  = HUNT;
                     locked_n = 1'b0;
                     match_n  = '0;
                     miss_n   = '0;
                  end
               end
            end
            default: begin
               state_n  = HUNT;
               locked_n = 1'b0;
               match_n  = '0;
               miss_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker; a second instance with ERR_W=2, LOSS_COUNT=15 covers saturation.
module tb_lfsr_checker;

   logic       clk;
   logic       reset;
   logic       dataValid;
   logic [3:0] dataIn;
   logic       locked, errorPulse;
   logic [7:0] errorCount;
   logic [3:0] expected;
   logic       s_locked, s_errorPulse;
   logic [1:0] s_errorCount;
   logic [3:0] s_expected;

   int pass_cnt = 0;
   int total_cnt = 0;

   lfsr_checker u_dut (
      .clk        (clk),
      .reset      (reset),
      .dataValid  (dataValid),
      .dataIn     (dataIn),
      .locked     (locked),
      .errorPulse (errorPulse),
      .errorCount (errorCount),
      .expected   (expected)
   );

   lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .ERR_W(2)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .dataValid  (dataValid),
      .dataIn     (dataIn),
      .locked     (s_locked),
      .errorPulse (s_errorPulse),
      .errorCount (s_errorCount),
      .expected   (s_expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one sample for exactly one rising edge, then settle 1 time unit past it.
   task automatic send(input logic v, input logic [3:0] d);
      @(negedge clk);
      dataValid = v;
      dataIn    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      dataValid = 1'b0;
      dataIn    = 4'h0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total_cnt++;
      if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked);
      else pass_cnt++;
      total_cnt++;
      if (errorPulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", errorPulse);
      else pass_cnt++;
      total_cnt++;
      if (errorCount !== 8'd0) $display("FAIL reset_count got %0d want 0", errorCount);
      else pass_cnt++;
      total_cnt++;
      if (expected !== 4'h0) $display("FAIL reset_expected got %h want 0", expected);
      else pass_cnt++;
   endtask

   task automatic test_lock();
      logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h4, 4'h9};
      do_reset();
      for (int i = 0; i < 4; i++) send(1'b1, seq[i]);
      total_cnt++;
      if (locked !== 1'b0) $display("FAIL lock_early got %b want 0", locked);
      else pass_cnt++;
      send(1'b1, 4'h3);
      total_cnt++;
      if (locked !== 1'b1 || expected !== 4'h6 || errorCount !== 8'd0)
         $display("FAIL lock_acquire got locked=%b exp=%h err=%0d want 1/6/0", locked, expected, errorCount);
      else pass_cnt++;
   endtask

   task automatic test_flywheel();
      send(1'b1, 4'h6);
      total_cnt++;
      if (errorPulse !== 1'b0 || expected !== 4'hD)
         $display("FAIL fly_match got pulse=%b exp=%h want 0/d", errorPulse, expected);
      else pass_cnt++;
      send(1'b1, 4'hC);
      total_cnt++;
      if (errorPulse !== 1'b1 || errorCount !== 8'd1 || expected !== 4'hA || locked !== 1'b1)
         $display("FAIL fly_error got pulse=%b err=%0d exp=%h lk=%b want 1/1/a/1",
                  errorPulse, errorCount, expected, locked);
      else pass_cnt++;
      send(1'b1, 4'hA);
      total_cnt++;
      if (errorPulse !== 1'b0 || expected !== 4'h5 || locked !== 1'b1 || errorCount !== 8'd1)
         $display("FAIL fly_recover got pulse=%b exp=%h lk=%b err=%0d want 0/5/1/1",
                  errorPulse, expected, locked, errorCount);
      else pass_cnt++;
   endtask

   task automatic test_loss();
      logic [3:0] exp_after [3] = '{4'hB, 4'h7, 4'hF};
      logic [3:0] relock [4] = '{4'h8, 4'h1, 4'h2, 4'h4};
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 4'h0);
         total_cnt++;
         if (errorPulse !== 1'b1 || errorCount !== 8'(i + 2) || expected !== exp_after[i])
            $display("FAIL loss_miss%0d got pulse=%b err=%0d exp=%h want 1/%0d/%h",
                     i, errorPulse, errorCount, expected, i + 2, exp_after[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (locked !== 1'b0) $display("FAIL loss_unlock got %b want 0", locked);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) send(1'b1, relock[i]);
      total_cnt++;
      if (locked !== 1'b0) $display("FAIL relock_early got %b want 0", locked);
      else pass_cnt++;
      send(1'b1, 4'h9);
      total_cnt++;
      if (locked !== 1'b1 || expected !== 4'h3 || errorCount !== 8'd4)
         $display("FAIL relock got lk=%b exp=%h err=%0d want 1/3/4", locked, expected, errorCount);
      else pass_cnt++;
   endtask

   task automatic test_reseed();
      logic [3:0] seq [4] = '{4'hE, 4'hC, 4'h8, 4'h1};
      do_reset();
      send(1'b1, 4'h1);
      send(1'b1, 4'h2);
      send(1'b1, 4'h7);
      total_cnt++;
      if (expected !== 4'hF || locked !== 1'b0)
         $display("FAIL reseed_seed got exp=%h lk=%b want f/0", expected, locked);
      else pass_cnt++;
      // E mispredicts against F and reseeds; C,8,1 then give only three matches.
      for (int i = 0; i < 4; i++) send(1'b1, seq[i]);
      total_cnt++;
      if (locked !== 1'b0 || expected !== 4'h2)
         $display("FAIL reseed_pending got lk=%b exp=%h want 0/2", locked, expected);
      else pass_cnt++;
      send(1'b1, 4'h2);
      total_cnt++;
      if (locked !== 1'b1 || expected !== 4'h4 || errorCount !== 8'd0)
         $display("FAIL reseed_lock got lk=%b exp=%h err=%0d want 1/4/0", locked, expected, errorCount);
      else pass_cnt++;
   endtask

   task automatic test_gaps();
      do_reset();
      send(1'b1, 4'h1);
      send(1'b0, 4'h7);
      total_cnt++;
      if (expected !== 4'h2 || errorPulse !== 1'b0)
         $display("FAIL gap_hold got exp=%h pulse=%b want 2/0", expected, errorPulse);
      else pass_cnt++;
      send(1'b1, 4'h2);
      send(1'b0, 4'h0);
      send(1'b1, 4'h4);
      send(1'b0, 4'hF);
      send(1'b1, 4'h9);
      send(1'b0, 4'h0);
      total_cnt++;
      if (locked !== 1'b0 || expected !== 4'h3)
         $display("FAIL gap_prelock got lk=%b exp=%h want 0/3", locked, expected);
      else pass_cnt++;
      send(1'b1, 4'h3);
      total_cnt++;
      if (locked !== 1'b1 || expected !== 4'h6 || errorCount !== 8'd0)
         $display("FAIL gap_lock got lk=%b exp=%h err=%0d want 1/6/0", locked, expected, errorCount);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};
      do_reset();
      for (int i = 0; i < 5; i++) send(1'b1, seq[i]);
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 4'h0);
         total_cnt++;
         if (s_errorCount !== want[i] || s_errorPulse !== 1'b1 || s_locked !== 1'b1)
            $display("FAIL sat_%0d got err=%0d pulse=%b lk=%b want %0d/1/1",
                     i, s_errorCount, s_errorPulse, s_locked, want[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};
      do_reset();
      for (int i = 0; i < 5; i++) send(1'b1, seq[i]);
      send(1'b1, 4'hC);
      total_cnt++;
      if (locked !== 1'b1 || errorCount !== 8'd1)
         $display("FAIL areset_pre got lk=%b err=%0d want 1/1", locked, errorCount);
      else pass_cnt++;
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (locked !== 1'b0 || errorCount !== 8'd0 || expected !== 4'h0 || errorPulse !== 1'b0)
         $display("FAIL areset_clear got lk=%b err=%0d exp=%h pulse=%b want 0/0/0/0",
                  locked, errorCount, expected, errorPulse);
      else pass_cnt++;
      @(negedge clk);
      reset     = 1'b0;
      dataValid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      dataValid = 1'b0;
      dataIn    = 4'h0;
      test_reset();
      test_lock();
      test_flywheel();
      test_loss();
      test_reseed();
      test_gaps();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
